// File: rtl/sequential_divider_32.sv
// Multicycle signed divider: radix-2 restoring division on magnitudes, one trial
// subtraction per cycle, with the signs fixed up once the magnitudes are done.
module sequential_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   rem, shifted, trial;
    logic [WIDTH-1:0] quo, divisor, abs_a, abs_b;
    logic [CW-1:0]    cnt;
    logic             sign_q, sign_r, exc, div_zero;

    assign abs_a    = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    assign abs_b    = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
    assign div_zero = (data_operandB == '0);

    // rem < divisor <= 2^(WIDTH-1), so the shifted value never reaches bit WIDTH
    // and trial[WIDTH] is a reliable sign bit.
    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};

    assign busy = (state != IDLE) || data_resultRDY;

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ctrl_div) begin
            state_nxt = div_zero ? DONE : RUN;
        end else begin
            case (state)
                RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
                FIX:     state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rem            <= '0;
            quo            <= '0;
            divisor        <= '0;
            cnt            <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            exc            <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_div) begin
                sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                sign_r  <= data_operandA[WIDTH-1];
                divisor <= abs_b;
                cnt     <= '0;
                if (div_zero) begin
                    quo <= '0;
                    rem <= {1'b0, data_operandA};
                    exc <= 1'b1;
                end else begin
                    quo <= abs_a;
                    rem <= '0;
                    exc <= 1'b0;
                end
            end else begin
                case (state)
                    RUN: begin
                        cnt <= cnt + CW'(1);
                        if (!trial[WIDTH]) begin
                            rem <= trial;
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted;
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                    end
                    FIX: begin
                        quo <= sign_q ? -quo : quo;
                        rem <= {1'b0, sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]};
                    end
                    default: ;
                endcase
            end
            // Outputs load from the internal registers' old values, so a restart
            // accepted in DONE still reports the finished operation.
            if (state == DONE) begin
                data_result    <= quo;
                data_remainder <= rem[WIDTH-1:0];
                data_exception <= exc;
                data_resultRDY <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sequential_divider_32.sv
// Bench for sequential_divider_32: directed vector table, abort/reset sequences and a
// randomized back-to-back stream checked against C-style signed / and %.
module tb_sequential_divider_32;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_div = 1'b0;
    logic [31:0] data_operandA = '0, data_operandB = '0;
    logic [31:0] data_result, data_remainder;
    logic        data_exception, data_resultRDY, busy;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int NRAND = 800;

    sequential_divider_32 #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .ctrl_div(ctrl_div),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_remainder(data_remainder),
        .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a, b, q, r;
        logic        exc;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint la, lb;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        q  = 32'(la / lb);
        r  = 32'(la % lb);
    endfunction

    // Returns at the negedge following the start edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_div = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_div = 1'b0;
    endtask

    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, pulses, busy_seen, spurious;
        logic [31:0] cq, cr, a, b, pa, pb, eq, er;
        logic pend;

        vecs[0]  = '{32'd100,       32'd7,          32'd14,         32'd2,          1'b0, 34};
        vecs[1]  = '{-32'sd100,     32'd7,          -32'sd14,       -32'sd2,        1'b0, 34};
        vecs[2]  = '{32'd100,       -32'sd7,        -32'sd14,       32'd2,          1'b0, 34};
        vecs[3]  = '{-32'sd100,     -32'sd7,        32'd14,         -32'sd2,        1'b0, 34};
        vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34};
        vecs[5]  = '{32'd5,         32'd0,          32'd0,          32'd5,          1'b1, 1};
        vecs[6]  = '{32'd0,         32'd5,          32'd0,          32'd0,          1'b0, 34};
        vecs[7]  = '{32'd7,         32'd100,        32'd0,          32'd7,          1'b0, 34};
        vecs[8]  = '{32'h7FFF_FFFF, -32'sd2,        32'hC000_0001,  32'd1,          1'b0, 34};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000,  32'd1,          32'd0,          1'b0, 34};
        vecs[10] = '{32'hFFFF_FFFF, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0, 34};
        vecs[11] = '{-32'sd9,       32'd0,          32'd0,          -32'sd9,        1'b1, 1};

        // Reset held three cycles.
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_result", data_result, 32'd0);
        check("rst_remainder", data_remainder, 32'd0);
        check("rst_exc", 32'(data_exception), 32'd0);
        check("rst_rdy", 32'(data_resultRDY), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY || busy) pulses++;
        end
        check("idle_no_rdy", 32'(pulses), 32'd0);

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy_start", i), 32'(busy), 32'd1);
            wait_rdy(lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_quot", i), data_result, vecs[i].q);
            check($sformatf("v%0d_rem", i), data_remainder, vecs[i].r);
            check($sformatf("v%0d_exc", i), 32'(data_exception), 32'(vecs[i].exc));
            check($sformatf("v%0d_busy_rdy", i), 32'(busy), 32'd1);
            @(posedge clock);
            @(negedge clock);
            check($sformatf("v%0d_rdy_drop", i), 32'(data_resultRDY), 32'd0);
            check($sformatf("v%0d_busy_drop", i), 32'(busy), 32'd0);
        end

        // Restart at cycle 10 aborts the first op; only the second completes.
        start_op(32'd100, 32'd7);
        repeat (9) begin
            @(posedge clock);
            @(negedge clock);
        end
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        ctrl_div = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_div = 1'b0;
        pulses = 0;
        lat = -1;
        cq = '1;
        cr = '1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    cq = data_result;
                    cr = data_remainder;
                end
            end
        end
        check("abort_pulses", 32'(pulses), 32'd1);
        check("abort_latency", 32'(lat), 32'd34);
        check("abort_quot", cq, 32'd3);
        check("abort_rem", cr, 32'd0);

        // Reset at cycle 10 kills the op silently.
        start_op(32'd100, 32'd7);
        repeat (9) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check("rabort_result", data_result, 32'd0);
        check("rabort_remainder", data_remainder, 32'd0);
        check("rabort_exc", 32'(data_exception), 32'd0);
        pulses = 0;
        busy_seen = 0;
        repeat (50) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) pulses++;
            if (busy) busy_seen++;
        end
        check("rabort_no_rdy", 32'(pulses), 32'd0);
        check("rabort_no_busy", 32'(busy_seen), 32'd0);

        // Random back-to-back stream: each new start lands on the previous op's DONE cycle.
        pend = 1'b0;
        spurious = 0;
        pa = '0;
        pb = '0;
        a = '0;
        b = '0;
        for (int i = 0; i <= NRAND; i++) begin
            if (i < NRAND) begin
                a = $urandom;
                case ($urandom_range(0, 3))
                    0:       b = 32'($urandom_range(1, 20));
                    1:       b = -32'($urandom_range(1, 20));
                    2:       b = {$urandom_range(0, 1) == 0 ? 16'h0000 : 16'hFFFF, 16'($urandom)};
                    default: b = $urandom;
                endcase
                if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
                if (b == 32'd0) b = 32'd1;
                data_operandA = a;
                data_operandB = b;
                ctrl_div = 1'b1;
            end
            @(posedge clock);
            @(negedge clock);
            ctrl_div = 1'b0;
            if (pend) begin
                ref_div(pa, pb, eq, er);
                check($sformatf("rnd%0d_rdy", i - 1), 32'(data_resultRDY), 32'd1);
                check($sformatf("rnd%0d_quot(%08h/%08h)", i - 1, pa, pb), data_result, eq);
                check($sformatf("rnd%0d_rem(%08h/%08h)", i - 1, pa, pb), data_remainder, er);
                check($sformatf("rnd%0d_exc", i - 1), 32'(data_exception), 32'd0);
            end
            if (i < NRAND) begin
                pa = a;
                pb = b;
                pend = 1'b1;
                repeat (33) begin
                    @(posedge clock);
                    @(negedge clock);
                    if (data_resultRDY) spurious++;
                end
            end
        end
        check("rnd_spurious_rdy", 32'(spurious), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
